// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the initiator and responder ends of the link.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_IDLE_FILL = 8'hFF;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus rise/fall pulses taken
// against a third (edge) register.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic edge_q;

  // Reset to the pin's idle level so releasing reset never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      edge_q <= RESET_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      edge_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~edge_q;
  assign fall = ~sync_q & edge_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples SCLK/CS_N/MOSI in the clk domain, shifts
// MSB first, with a valid/ready TX holding register and an RX strobe.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter logic [DATA_W-1:0] IDLE_FILL = SPI_IDLE_FILL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_e state, state_nxt;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_meta, mosi_s;

  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-2:0] rx_shift;
  logic [CNT_W-1:0]  bit_cnt;
  logic              reload;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;

  logic              start;
  logic              refill;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              load_empty;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .sync  (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs_n),
    .sync  (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // cs_n high wins over any SCLK edge; the level check also covers cs_rise
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_s)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start  = (state == IDLE) && cs_fall;
  assign refill = (state == ACTIVE) && !cs_s && sclk_fall && reload;
  assign load   = start || refill;

  // An empty holding register with a write in flight hands the new byte straight to the shifter
  assign load_data  = hold_full ? hold_data : (tx_valid ? tx_data : IDLE_FILL);
  assign load_empty = !hold_full && !tx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_data <= tx_data;
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      reload      <= 1'b0;
      miso        <= 1'b1;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (state == ACTIVE && cs_s) begin
        rx_shift <= '0;
        bit_cnt  <= '0;
        reload   <= 1'b0;
        miso     <= 1'b1;
        miso_oe  <= 1'b0;
      end else if (start) begin
        tx_shift    <= load_data;
        miso        <= load_data[DATA_W-1];
        miso_oe     <= 1'b1;
        rx_shift    <= '0;
        bit_cnt     <= '0;
        reload      <= 1'b0;
        tx_underrun <= load_empty;
      end else if (state == ACTIVE) begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt  <= '0;
            rx_data  <= {rx_shift, mosi_s};
            rx_valid <= 1'b1;
            reload   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else if (sclk_fall) begin
          if (reload) begin
            tx_shift    <= load_data;
            miso        <= load_data[DATA_W-1];
            tx_underrun <= load_empty;
            reload      <= 1'b0;
          end else begin
            tx_shift <= tx_shift << 1;
            miso     <= tx_shift[DATA_W-2];
          end
        end
      end
    end
  end

  assign tx_ready = !hold_full;
  assign busy     = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master at clk/8 drives
// frames, and each observation is checked against hand-computed values.
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         rx_count = 0;
  int         urun_count = 0;
  logic [7:0] rx_log[$];
  logic [7:0] got, got2;

  spi_slave dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes last exactly one cycle, so each one crosses exactly one falling edge
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_count++;
      rx_log.push_back(rx_data);
    end
    if (tx_underrun) urun_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] rxAt(input int idx);
    if (idx < rx_log.size()) return rx_log[idx];
    return 8'hxx;
  endfunction

  task automatic preload(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic selectSlave();
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic deselectSlave();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Master shifts nbits of mosi_byte; optionally writes wr_byte into the TX register mid-byte
  task automatic applyStimulus(input logic [7:0] mosi_byte, input int nbits, input logic wr_en,
                               input logic [7:0] wr_byte, output logic [7:0] miso_got);
    miso_got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_byte[7-i];
      if (wr_en && i == 3) begin
        tx_data  = wr_byte;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      miso_got[7-i] = miso;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_miso", 32'(miso), 32'h1);
    checkOutput("rst_miso_oe", 32'(miso_oe), 32'h0);
    checkOutput("rst_tx_ready", 32'(tx_ready), 32'h1);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'h0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'h0);
    checkOutput("rst_tx_underrun", 32'(tx_underrun), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: preloaded A5 out, 3C in
    preload(8'hA5);
    checkOutput("t1_ready_full", 32'(tx_ready), 32'h0);
    selectSlave();
    checkOutput("t1_miso_oe", 32'(miso_oe), 32'h1);
    checkOutput("t1_busy", 32'(busy), 32'h1);
    checkOutput("t1_ready_after_load", 32'(tx_ready), 32'h1);
    applyStimulus(8'h3C, 8, 1'b1, 8'h12, got);
    checkOutput("t1_miso_byte", 32'(got), 32'hA5);
    checkOutput("t1_rx_count", 32'(rx_count), 32'd1);
    checkOutput("t1_rx_data", 32'(rxAt(0)), 32'h3C);
    checkOutput("t1_underruns", 32'(urun_count), 32'd0);
    deselectSlave();
    checkOutput("t1_oe_off", 32'(miso_oe), 32'h0);
    checkOutput("t1_idle", 32'(busy), 32'h0);
    checkOutput("t1_ready_end", 32'(tx_ready), 32'h1);

    // Back-to-back bytes: 12 then 34 on MISO, 5A then C3 on MOSI
    preload(8'h12);
    selectSlave();
    applyStimulus(8'h5A, 8, 1'b1, 8'h34, got);
    applyStimulus(8'hC3, 8, 1'b1, 8'h00, got2);
    checkOutput("t2_miso_b0", 32'(got), 32'h12);
    checkOutput("t2_miso_b1", 32'(got2), 32'h34);
    checkOutput("t2_rx_count", 32'(rx_count), 32'd3);
    checkOutput("t2_rx_b0", 32'(rxAt(1)), 32'h5A);
    checkOutput("t2_rx_b1", 32'(rxAt(2)), 32'hC3);
    checkOutput("t2_underruns", 32'(urun_count), 32'd0);
    deselectSlave();

    // Underrun: nothing held at select
    selectSlave();
    checkOutput("t3_underrun_at_select", 32'(urun_count), 32'd1);
    applyStimulus(8'h96, 8, 1'b1, 8'h00, got);
    checkOutput("t3_miso_fill", 32'(got), 32'hFF);
    checkOutput("t3_rx_count", 32'(rx_count), 32'd4);
    checkOutput("t3_rx_data", 32'(rxAt(3)), 32'h96);
    checkOutput("t3_underruns", 32'(urun_count), 32'd1);
    deselectSlave();

    // Deselect after 5 bits, then a full frame
    preload(8'hAA);
    selectSlave();
    applyStimulus(8'hE1, 5, 1'b0, 8'h00, got);
    checkOutput("t4_partial_miso", 32'(got), 32'hA8);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t4_oe_off", 32'(miso_oe), 32'h0);
    checkOutput("t4_miso_high", 32'(miso), 32'h1);
    checkOutput("t4_idle", 32'(busy), 32'h0);
    checkOutput("t4_no_rx", 32'(rx_count), 32'd4);
    repeat (5) @(negedge clk);
    preload(8'h5C);
    selectSlave();
    applyStimulus(8'hE7, 8, 1'b1, 8'h00, got);
    checkOutput("t4_next_miso", 32'(got), 32'h5C);
    checkOutput("t4_next_rx_count", 32'(rx_count), 32'd5);
    checkOutput("t4_next_rx_data", 32'(rxAt(4)), 32'hE7);
    checkOutput("t4_underruns", 32'(urun_count), 32'd1);
    deselectSlave();

    // Asynchronous reset mid-frame with the holding register full
    preload(8'h0F);
    selectSlave();
    applyStimulus(8'h99, 3, 1'b0, 8'h00, got);
    preload(8'h3A);
    checkOutput("t5_ready_full", 32'(tx_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_miso", 32'(miso), 32'h1);
    checkOutput("t5_miso_oe", 32'(miso_oe), 32'h0);
    checkOutput("t5_tx_ready", 32'(tx_ready), 32'h1);
    checkOutput("t5_rx_data", 32'(rx_data), 32'h0);
    checkOutput("t5_rx_valid", 32'(rx_valid), 32'h0);
    checkOutput("t5_busy", 32'(busy), 32'h0);
    cs_n = 1'b1;
    sclk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    preload(8'h81);
    selectSlave();
    applyStimulus(8'h42, 8, 1'b1, 8'h00, got);
    checkOutput("t5_after_miso", 32'(got), 32'h81);
    checkOutput("t5_after_rx_count", 32'(rx_count), 32'd6);
    checkOutput("t5_after_rx_data", 32'(rxAt(5)), 32'h42);
    deselectSlave();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Responder end of the team's SPI link: accepts bytes from an external SPI master (SCLK/CS_N/MOSI) and returns bytes on MISO, mode 0 (CPOL=0, CPHA=0), MSB first. All pins are oversampled in the `clk` domain. Parallel side is a valid/ready TX holding register and an RX strobe for the UDS layer. It complements the existing initiator-side `SPI` block, so the codebase covers both ends of the link.

## Interface
- `DATA_W`, 8: frame width in bits.
- `IDLE_FILL`, 8'hFF: byte shifted out when no TX data is held.
- `clk`  in  1  system clock; must be ≥ 8× SCLK frequency.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sclk`  in  1  SPI clock from master, asynchronous to `clk`.
- `cs_n`  in  1  chip select from master, active-low, asynchronous.
- `mosi`  in  1  serial data from master.
- `miso`  out  1  serial data to master.
- `miso_oe`  out  1  pad enable for `miso`; high only while selected.
- `tx_data`  in  DATA_W  next byte to send.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  holding register empty.
- `rx_data`  out  DATA_W  last received byte.
- `rx_valid`  out  1  one-cycle strobe, `rx_data` updated.
- `tx_underrun`  out  1  one-cycle strobe: `IDLE_FILL` loaded because holding register was empty.
- `busy`  out  1  high in ACTIVE.

## Operation
- `sclk`, `cs_n`, `mosi` pass through 2-FF synchronizers. Rise and fall pulses of `sclk` and the fall pulse of `cs_n` are derived from synchronized samples.
- FSM has two states:
  - IDLE → ACTIVE on synchronized `cs_n` fall.
  - ACTIVE → IDLE on synchronized `cs_n` high, checked every cycle with priority over SCLK edges.
- Entering ACTIVE:
  - Shifter loads the holding register, or `IDLE_FILL` with `tx_underrun` if empty.
  - `miso` = shifter MSB, `miso_oe` = 1, `bit_cnt` = 0.
- SCLK rise in ACTIVE:
  - `rx_shift` <= {`rx_shift`[DATA_W-2:0], `mosi_s`}; `bit_cnt`++.
  - When `bit_cnt` wraps DATA_W-1→0: `rx_data` <= assembled byte, `rx_valid` pulses, `reload` flag set.
- SCLK fall in ACTIVE:
  - If `reload`: shifter loads the holding register (or `IDLE_FILL` + `tx_underrun`), `miso` = new MSB, `reload` cleared.
  - Otherwise the shifter shifts left and `miso` = next bit.
- Holding register:
  - Written when `tx_valid && tx_ready`; `tx_ready` then drops.
  - `tx_ready` returns high the cycle after the shifter takes the holding register.
  - A same-cycle write and shifter load passes the new data straight through and leaves `tx_ready` high.
- `rx_valid` has no backpressure. The consumer takes `rx_data` on the strobe; `rx_data` holds until the next byte.
- Deselect mid-byte (`cs_n` rises before `bit_cnt` wraps):
  - The partial byte is discarded with no `rx_valid`.
  - `bit_cnt` = 0, `reload` = 0, `miso_oe` = 0, `miso` = 1.
  - The holding register is retained.
- Edges seen while IDLE are ignored.

## Timing
- Reset values: `miso` = 1, `miso_oe` = 0, `tx_ready` = 1, `rx_valid` = 0, `rx_data` = 0, `tx_underrun` = 0, `busy` = 0; internal counters and shifters = 0.
- Pin-to-detection latency is 3 `clk`: 2 synchronizer stages plus the edge register.
- `rx_valid` asserts 3 `clk` after the 8th SCLK rise reaches the pin.
- `miso` updates 3 `clk` after an SCLK fall or `cs_n` fall at the pin.
- Master requirements:
  - Each SCLK half-period ≥ 4 `clk`.
  - `cs_n`-fall to first SCLK rise ≥ 4 `clk`.
  - Last SCLK fall to `cs_n` rise ≥ 4 `clk`.
- Back-to-back bytes need no gap; the next MSB appears on the falling edge that follows the 8th rise.

## Structure
- Package `spi_pkg`: `SPI_DATA_W` = 8, `SPI_IDLE_FILL` = 8'hFF, FSM state enum {IDLE, ACTIVE}. Shared with the initiator.
- Sub-module `spi_sync_edge`: 2-FF synchronizer plus rise/fall pulse outputs. Instantiated for `sclk` and `cs_n`; `mosi` uses only its synchronized output.

## Test plan
- Preload 8'hA5, select, clock 8 bits of MOSI 8'h3C at `clk`/8 → `miso` bits 1,0,1,0,0,1,0,1; one `rx_valid` with `rx_data` = 8'h3C; `tx_ready` high after load.
- Two back-to-back bytes with `tx_data` 8'h12 then 8'h34 written while the first shifts → MISO 8'h12 then 8'h34 with no gap; two `rx_valid` pulses.
- Select with no TX data → MISO 8'hFF, one `tx_underrun` pulse; RX still correct.
- Deselect after 5 bits → no `rx_valid`, `miso_oe` = 0 within 3 `clk`; the next full frame receives correctly from bit 0.
- Assert `rst_n` low mid-frame → all outputs return to reset values asynchronously; the frame after release (`cs_n` high first) works.
